// File: rtl/logic_bank_sweeper.sv
// logic_bank_sweeper: walks the logic bank through a vector range,
// compacting sampled results into a MISR and counting pattern hits.
module logic_bank_sweeper #(
  parameter int VEC_W = 16,
  parameter int RES_W = 8,
  parameter int SIG_W = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(16'h8016),
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [VEC_W-1:0] start_vec,
  input  logic [VEC_W-1:0] end_vec,
  input  logic [RES_W-1:0] match_mask,
  input  logic [RES_W-1:0] match_val,
  output logic [VEC_W-1:0] bank_in,
  input  logic [RES_W-1:0] bank_out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [SIG_W-1:0] signature,
  output logic [SIG_W-1:0] hit_count
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SAMPLE,
    FIN
  } state_t;

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);
  localparam state_t FIRST = (SETTLE > 0) ? HOLD : SAMPLE;

  state_t           state_q;
  logic [VEC_W-1:0] vec_q;
  logic [VEC_W-1:0] end_q;
  logic [RES_W-1:0] mask_q;
  logic [RES_W-1:0] val_q;
  logic [3:0]       cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             abt_q;
  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] hit_q;

  logic             match;
  logic [SIG_W-1:0] sig_d;
  logic [SIG_W-1:0] hit_d;

  always_comb begin
    match = ((bank_out ^ val_q) & mask_q) == '0;
    sig_d = {sig_q[SIG_W-2:0], 1'b0}
          ^ (sig_q[SIG_W-1] ? SIG_POLY : '0)
          ^ SIG_W'(bank_out);
    hit_d = hit_q;
    if (match && (hit_q != '1)) begin
      hit_d = hit_q + SIG_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      end_q   <= '0;
      mask_q  <= '0;
      val_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abt_q   <= 1'b0;
      sig_q   <= '0;
      hit_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            vec_q   <= start_vec;
            end_q   <= end_vec;
            mask_q  <= match_mask;
            val_q   <= match_val;
            cnt_q   <= SETTLE_L;
            sig_q   <= '0;
            hit_q   <= '0;
            abt_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= FIRST;
          end
        end
        HOLD: begin
          if (abort) begin
            abt_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
              state_q <= SAMPLE;
            end
          end
        end
        SAMPLE: begin
          // abort wins: the current vector is dropped unsampled
          if (abort) begin
            abt_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            sig_q <= sig_d;
            hit_q <= hit_d;
            if (vec_q == end_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              vec_q   <= vec_q + VEC_W'(1);
              cnt_q   <= SETTLE_L;
              state_q <= FIRST;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bank_in   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = abt_q;
  assign signature = sig_q;
  assign hit_count = hit_q;

endmodule

// File: tb/tb_logic_bank_sweeper.sv
// tb_logic_bank_sweeper: randomized sweeps of three builds checked
// against a range-walking reference model of bank, MISR and counter.
module tb_logic_bank_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        st_a, st_b, st_c;
  logic        abort;
  logic [15:0] sv_i, ev_i;
  logic [7:0]  mk_i, vl_i;
  int          lb;

  logic [15:0] bin_a, bin_b, bin_c;
  logic [7:0]  bo_a, bo_b;
  logic [3:0]  bo_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        ab_a, ab_b, ab_c;
  logic [15:0] sig_a, sig_b, hit_a, hit_b;
  logic [3:0]  sig_c, hit_c;

  int nvec = 0;
  int nerr = 0;

  function automatic int bout(input int v, input int mode);
    if (mode != 0) return v & 'hFF;
    return ((v ^ (v >> 8) ^ (v >> 5)) & 'hFF) ^ 'h3C;
  endfunction

  assign bo_a = 8'(bout(int'(bin_a), lb));
  assign bo_b = 8'(bout(int'(bin_b), lb));
  assign bo_c = 4'(bout(int'(bin_c), lb));

  logic_bank_sweeper #(.SETTLE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(st_a), .abort(abort),
    .start_vec(sv_i), .end_vec(ev_i),
    .match_mask(mk_i), .match_val(vl_i),
    .bank_in(bin_a), .bank_out(bo_a),
    .busy(busy_a), .done(done_a), .aborted(ab_a),
    .signature(sig_a), .hit_count(hit_a)
  );

  logic_bank_sweeper #(.SETTLE(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(st_b), .abort(abort),
    .start_vec(sv_i), .end_vec(ev_i),
    .match_mask(mk_i), .match_val(vl_i),
    .bank_in(bin_b), .bank_out(bo_b),
    .busy(busy_b), .done(done_b), .aborted(ab_b),
    .signature(sig_b), .hit_count(hit_b)
  );

  logic_bank_sweeper #(
    .RES_W(4), .SIG_W(4), .SIG_POLY(4'h9)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .start(st_c), .abort(abort),
    .start_vec(sv_i), .end_vec(ev_i),
    .match_mask(mk_i[3:0]), .match_val(vl_i[3:0]),
    .bank_in(bin_c), .bank_out(bo_c),
    .busy(busy_c), .done(done_c), .aborted(ab_c),
    .signature(sig_c), .hit_count(hit_c)
  );

  function automatic logic get_busy(input int sel);
    return sel == 0 ? busy_a : sel == 1 ? busy_b : busy_c;
  endfunction

  function automatic logic get_done(input int sel);
    return sel == 0 ? done_a : sel == 1 ? done_b : done_c;
  endfunction

  function automatic logic get_ab(input int sel);
    return sel == 0 ? ab_a : sel == 1 ? ab_b : ab_c;
  endfunction

  function automatic logic [15:0] get_bin(input int sel);
    return sel == 0 ? bin_a : sel == 1 ? bin_b : bin_c;
  endfunction

  function automatic logic [15:0] get_sig(input int sel);
    return sel == 0 ? sig_a : sel == 1 ? sig_b : {12'h0, sig_c};
  endfunction

  function automatic logic [15:0] get_hit(input int sel);
    return sel == 0 ? hit_a : sel == 1 ? hit_b : {12'h0, hit_c};
  endfunction

  task automatic set_start(input int sel, input logic v);
    st_a = (sel == 0) ? v : 1'b0;
    st_b = (sel == 1) ? v : 1'b0;
    st_c = (sel == 2) ? v : 1'b0;
  endtask

  // Reference: visit nsamp vectors upward from sv, fold each result
  // into the MISR and count masked matches with saturation.
  function automatic void model(
    input int sw, input int rw, input int poly, input int sv,
    input int nsamp, input int mk, input int vl, input int mode,
    output int sig, output int hits
  );
    int smask, rmask, v, bo, top;
    smask = (1 << sw) - 1;
    rmask = (1 << rw) - 1;
    sig = 0;
    hits = 0;
    for (int i = 0; i < nsamp; i++) begin
      v = (sv + i) & 'hFFFF;
      bo = bout(v, mode) & rmask;
      top = (sig >> (sw - 1)) & 1;
      sig = ((sig << 1) & smask) ^ (top != 0 ? poly : 0) ^ bo;
      if (((bo ^ vl) & mk & rmask) == 0 && hits < smask) hits++;
    end
  endfunction

  task automatic run_sweep(
    input int sel, input int sv, input int ev, input int mk,
    input int vl, input int abort_at, input bit inj
  );
    int s, sw, rw, poly, n, nsamp, cyc, sig_e, hit_e;
    bit ab_e, seq_ok;
    int exp_q[$];
    int got_q[$];
    s = (sel == 0) ? 0 : (sel == 1) ? 2 : 1;
    sw = (sel == 2) ? 4 : 16;
    rw = (sel == 2) ? 4 : 8;
    poly = (sel == 2) ? 'h9 : 'h8016;
    sv = sv & 'hFFFF;
    ev = ev & 'hFFFF;
    n = ((ev - sv) & 'hFFFF) + 1;
    ab_e = (abort_at >= 0) && (abort_at < n);
    nsamp = ab_e ? abort_at : n;
    for (int i = 0; i < nsamp; i++)
      for (int k = 0; k <= s; k++)
        exp_q.push_back((sv + i) & 'hFFFF);
    if (ab_e) exp_q.push_back((sv + abort_at) & 'hFFFF);
    model(sw, rw, poly, sv, nsamp, mk, vl, lb, sig_e, hit_e);

    @(negedge clk);
    sv_i = 16'(sv);
    ev_i = 16'(ev);
    mk_i = 8'(mk);
    vl_i = 8'(vl);
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    cyc = 0;
    while (get_busy(sel) === 1'b1 && cyc < 2000) begin
      got_q.push_back(int'(get_bin(sel)));
      abort = ab_e && (cyc == abort_at * (s + 1));
      set_start(sel, inj && cyc == 1);
      sv_i = 16'($urandom);
      ev_i = 16'($urandom);
      mk_i = 8'($urandom);
      vl_i = 8'($urandom);
      @(negedge clk);
      cyc++;
    end
    abort = 1'b0;
    set_start(sel, 1'b0);
    if (cyc >= 2000) begin
      nerr++;
      $display("FAIL timeout: busy still %b after %0d cycles, need 0",
               get_busy(sel), cyc);
    end
    nvec++;
    if (get_done(sel) !== 1'b1) begin
      nerr++;
      $display("FAIL done: got %b, need 1", get_done(sel));
    end
    if (inj) set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    nvec++;
    if (get_done(sel) !== 1'b0 || get_busy(sel) !== 1'b0) begin
      nerr++;
      $display("FAIL done_pulse: done %b busy %b, need 0 0",
               get_done(sel), get_busy(sel));
    end
    nvec++;
    seq_ok = got_q.size() == exp_q.size();
    if (seq_ok)
      foreach (exp_q[i]) if (got_q[i] != exp_q[i]) seq_ok = 1'b0;
    if (!seq_ok) begin
      nerr++;
      $display("FAIL seq: got %0d cycles first %h, need %0d first %h",
               got_q.size(), got_q.size() > 0 ? got_q[0] : -1,
               exp_q.size(), exp_q.size() > 0 ? exp_q[0] : -1);
    end
    nvec++;
    if (get_sig(sel) !== 16'(sig_e)) begin
      nerr++;
      $display("FAIL sig: got %h, need %h", get_sig(sel), 16'(sig_e));
    end
    nvec++;
    if (get_hit(sel) !== 16'(hit_e)) begin
      nerr++;
      $display("FAIL hits: got %h, need %h", get_hit(sel), 16'(hit_e));
    end
    nvec++;
    if (get_ab(sel) !== ab_e) begin
      nerr++;
      $display("FAIL aborted: got %b, need %b", get_ab(sel), ab_e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    abort = 1'b0;
    set_start(0, 1'b0);
    sv_i = '0;
    ev_i = '0;
    mk_i = '0;
    vl_i = '0;
    lb = 1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      nvec++;
      if ({get_bin(s), get_busy(s), get_done(s), get_ab(s),
           get_sig(s), get_hit(s)} !== '0) begin
        nerr++;
        $display("FAIL reset%0d: bin %h busy %b sig %h hit %h, need 0",
                 s, get_bin(s), get_busy(s), get_sig(s), get_hit(s));
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_loopback();
    lb = 1;
    run_sweep(0, 0, 3, 'h01, 'h01, -1, 0);
    nvec++;
    if (sig_a !== 16'h0003 || hit_a !== 16'd2) begin
      nerr++;
      $display("FAIL loopback: sig %h hit %0d, need 0003 2",
               sig_a, hit_a);
    end
  endtask

  task automatic test_settle();
    lb = 1;
    run_sweep(1, 0, 3, 'h01, 'h01, -1, 0);
    nvec++;
    if (sig_b !== 16'h0003 || hit_b !== 16'd2) begin
      nerr++;
      $display("FAIL settle: sig %h hit %0d, need 0003 2",
               sig_b, hit_b);
    end
  endtask

  task automatic test_wrap();
    lb = 0;
    run_sweep(0, 'hFFFE, 'h0001, 'hF0, 'h30, -1, 0);
    run_sweep(1, 'hFFFE, 'h0001, 'h0F, 'h05, -1, 0);
    run_sweep(0, 'h1234, 'h1234, 'h00, 'h00, -1, 0);
    run_sweep(1, 'h1234, 'h1234, 'hFF, 'h00, -1, 0);
  endtask

  task automatic test_abort();
    lb = 1;
    run_sweep(0, 0, 9, 'h01, 'h01, 2, 1);
    run_sweep(1, 0, 9, 'h01, 'h01, 2, 1);
    run_sweep(0, 'h55, 'h60, 'h03, 'h01, 0, 1);
  endtask

  task automatic test_reset_mid();
    lb = 1;
    @(negedge clk);
    sv_i = 16'h0041;
    ev_i = 16'h0049;
    mk_i = 8'h00;
    vl_i = 8'h00;
    set_start(1, 1'b1);
    @(negedge clk);
    set_start(1, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if ({bin_b, busy_b, done_b, ab_b, sig_b, hit_b} !== '0) begin
      nerr++;
      $display("FAIL reset_mid: bin %h busy %b sig %h hit %h, need 0",
               bin_b, busy_b, sig_b, hit_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(1, 'h0005, 'h0008, 'hFF, 'h06, -1, 0);
  endtask

  task automatic test_saturation();
    int sv;
    lb = 0;
    sv = int'($urandom_range(0, 'hFFFF));
    run_sweep(2, sv, sv + 19, 'h00, int'($urandom_range(0, 15)), -1, 0);
    nvec++;
    if (hit_c !== 4'hF) begin
      nerr++;
      $display("FAIL saturate: got %h, need f", hit_c);
    end
  endtask

  task automatic test_random();
    int sel, sv, len, ab;
    for (int it = 0; it < 24; it++) begin
      sel = int'($urandom_range(0, 2));
      lb = int'($urandom_range(0, 1));
      sv = int'($urandom_range(0, 'hFFFF));
      len = int'($urandom_range(1, 20));
      ab = ($urandom_range(0, 3) == 0) ?
           int'($urandom_range(0, len + 1)) : -1;
      run_sweep(sel, sv, sv + len - 1, int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), ab,
                1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    lb = 0;
    run_sweep(0, 'h00F0, 'h0105, 'h80, 'h80, -1, 1);
    run_sweep(0, 'h0200, 'h0203, 'h81, 'h01, -1, 0);
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_settle();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_saturation();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
